// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver (and uart_tx).
// Contents: rx_state_e FSM encoding, clks_per_bit() rounding helper,
// default-build HALF_BIT and PTR_W localparams.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    // Rounded CLK_HZ/BAUD so the bit period error stays within half a clock.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int CLKS_PER_BIT = clks_per_bit(24000000, 115200);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int FIFO_DEPTH   = 16;
    localparam int PTR_W        = $clog2(FIFO_DEPTH) + 1;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and show-ahead read port of the UART receiver.
// Signals: i_rx serial line, i_ren pop request, o_rdata head byte,
// o_empty/o_full FIFO status, o_frame_err/o_overrun one-cycle error pulses.
// slave = receiver side, master = user side.
interface uart_rx_if;

    logic       i_rx;
    logic       i_ren;
    logic [7:0] o_rdata;
    logic       o_empty;
    logic       o_full;
    logic       o_frame_err;
    logic       o_overrun;

    modport slave  (input i_rx, i_ren, output o_rdata, o_empty, o_full, o_frame_err, o_overrun);
    modport master (output i_rx, i_ren, input o_rdata, o_empty, o_full, o_frame_err, o_overrun);

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, DEPTH a power of 2 (>= 2).
// Ports: i_clk, i_res_n (async active-low), i_push/i_wdata write side,
// i_pop read side, o_rdata = head entry, o_empty, o_full.
// A push while full is accepted only if a real pop happens in the same cycle;
// a pop while empty is ignored even if a push arrives in that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_res_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB tells a full ring from an empty one.
    assign o_empty = wptr_q == rptr_q;
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);
    assign o_rdata = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= i_wdata;
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with a show-ahead receive FIFO.
// Ports: i_clk, i_res_n (async active-low), bus (uart_rx_if.slave):
// i_rx line in, i_ren pop, o_rdata/o_empty/o_full FIFO read side,
// o_frame_err/o_overrun one-cycle error pulses.
// Macro UART_RX_MAJORITY_EN: every sample point becomes a 2-of-3 vote over
// the nominal cycle and its neighbours, costing one extra cycle of latency.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 24000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input logic     i_clk,
    input logic     i_res_n,
    uart_rx_if.slave bus
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int HB  = CPB / 2;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] HB_END  = CW'(HB - 1);
    localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);

    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shreg_q;
    logic [1:0]    sync_q;
    logic          armed_q, frame_err_q, overrun_q;
    logic          rx_s, line, smp, tick, push, push_ok;

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // The whole FSM runs one cycle behind rx_s so that the cycle after the
    // nominal sample is already known when the vote is taken.
    logic [1:0] hist_q;
    assign line = hist_q[0];
    assign smp  = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) hist_q <= 2'b11;
        else hist_q <= {hist_q[0], rx_s};
    end
`else
    assign line = rx_s;
    assign smp  = rx_s;
`endif

    assign tick    = cnt_q == (state_q == START ? HB_END : BIT_END);
    assign push    = state_q == STOP && tick && smp;
    // Full implies non-empty, so a pop request always frees a slot here.
    assign push_ok = ~bus.o_full | bus.i_ren;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            sync_q      <= 2'b11;
            armed_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.i_rx};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= cnt_q == BIT_END ? '0 : cnt_q + 1'b1;
            if (line) armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (armed_q && !line) state_q <= START;
                end
                START: if (tick) begin
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    state_q <= smp ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    shreg_q <= {smp, shreg_q[7:1]};
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == 3'd7) state_q <= STOP;
                end
                STOP: if (tick) begin
                    state_q <= IDLE;
                    if (smp) overrun_q <= ~push_ok;
                    else begin
                        // Disarm until the line is seen idle so a held break
                        // reports one framing error, not one per frame time.
                        frame_err_q <= 1'b1;
                        armed_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_res_n (i_res_n),
        .i_push  (push),
        .i_wdata (shreg_q),
        .i_pop   (bus.i_ren),
        .o_rdata (bus.o_rdata),
        .o_empty (bus.o_empty),
        .o_full  (bus.o_full)
    );

    assign bus.o_frame_err = frame_err_q;
    assign bus.o_overrun   = overrun_q;

endmodule
